// File: rtl/dl_pkg.sv
// Shared definitions for the delay-line measurement path: scheduler state
// encoding and the default window / settle lengths that the capture datapath
// also sizes itself from.
package dl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    CAPTURE,
    READOUT,
    HOLDOFF
  } dl_sched_state_t;

  localparam int DL_LENGTH_DEFAULT  = 16;
  localparam int DL_HOLDOFF_DEFAULT = 64;

endpackage

// File: rtl/dl_auto_timer.sv
// Periodic auto-trigger source. Counts 0..period-1 while enabled and flags the
// terminal count for one cycle. The period is latched at each wrap, so a new
// value on i_auto_period only takes effect at the next wrap or while disabled.
module dl_auto_timer #(
  parameter int P_PERIOD_W = 24
) (
  input  logic                  clk,
  input  logic                  i_nrst,
  input  logic                  i_auto_en,
  input  logic [P_PERIOD_W-1:0] i_auto_period,
  output logic                  o_auto_tick
);

  logic [P_PERIOD_W-1:0] cnt_q, cnt_d;
  logic [P_PERIOD_W-1:0] period_q, period_d;
  logic                  term;

  // Next counter / latched period, and the terminal-count tick.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the
    // branches below can leave it unassigned and infer a latch.
    cnt_d    = cnt_q;
    period_d = period_q;
    term     = i_auto_en && (period_q != '0) && (cnt_q == period_q - 1'b1);

    if (!i_auto_en || (period_q == '0)) begin
      cnt_d    = '0;
      period_d = i_auto_period;
    end else if (term) begin
      cnt_d    = '0;
      period_d = i_auto_period;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign o_auto_tick = term;

  // Counter and latched period registers.
  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      cnt_q    <= '0;
      period_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      cnt_q    <= cnt_d;
      period_q <= period_d;
    end
  end

endmodule

// File: rtl/dl_capture_sched.sv
// Delay-line measurement scheduler. Arbitrates manual and auto triggers, then
// per run issues a launch pulse, a P_DL_LENGTH-cycle capture window, a held
// result with valid/done handshake and a settle holdoff, repeated for a burst.
// All outputs come straight from flops.
module dl_capture_sched
  import dl_pkg::*;
#(
  parameter int P_DL_LENGTH = DL_LENGTH_DEFAULT,
  parameter int P_HOLDOFF   = DL_HOLDOFF_DEFAULT,
  parameter int P_PERIOD_W  = 24,
  parameter int P_BURST_W   = 8,
  parameter int P_DROP_W    = 8
) (
  input  logic                  clk,
  input  logic                  i_nrst,
  input  logic                  i_trig_manual,
  input  logic                  i_auto_en,
  input  logic [P_PERIOD_W-1:0] i_auto_period,
  input  logic [P_BURST_W-1:0]  i_burst_len,
  input  logic                  i_rd_done,
  input  logic                  i_abort,
  input  logic                  i_clr,
  output logic                  o_launch,
  output logic                  o_cap_en,
  output logic                  o_cap_valid,
  output logic                  o_busy,
  output logic [P_BURST_W-1:0]  o_burst_idx,
  output logic [P_DROP_W-1:0]   o_drop_cnt
);

  localparam int WIN_W  = $clog2(P_DL_LENGTH);
  localparam int HOLD_W = $clog2(P_HOLDOFF + 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(P_DL_LENGTH - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(P_HOLDOFF - 1);

  dl_sched_state_t       state_q, state_d;
  logic [WIN_W-1:0]      win_q, win_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [P_BURST_W-1:0]  idx_q, idx_d;
  logic [P_BURST_W-1:0]  len_q, len_d;
  logic                  pending_q, pending_d;
  logic [P_DROP_W-1:0]   drop_q, drop_d;
  logic                  launch_q, launch_d;
  logic                  cap_en_q, cap_en_d;
  logic                  cap_valid_q, cap_valid_d;
  logic                  busy_q, busy_d;
  logic                  drop_inc;
  logic                  auto_tick;

  dl_auto_timer #(
    .P_PERIOD_W (P_PERIOD_W)
  ) u_auto_timer (
    .clk           (clk),
    .i_nrst        (i_nrst),
    .i_auto_en     (i_auto_en),
    .i_auto_period (i_auto_period),
    .o_auto_tick   (auto_tick)
  );

  // Next-state, counters, arbitration and registered-output decode.
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    hold_d    = hold_q;
    idx_d     = idx_q;
    len_d     = len_q;
    pending_d = pending_q;
    drop_inc  = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_trig_manual || pending_q || auto_tick) begin
          state_d   = LAUNCH;
          len_d     = (i_burst_len == '0) ? P_BURST_W'(1) : i_burst_len;
          pending_d = 1'b0;
          win_d     = '0;
          // Only one request starts a run; any second one in the cycle is lost.
          drop_inc  = (i_trig_manual && pending_q) ||
                      (auto_tick && (i_trig_manual || pending_q));
        end
      end
      LAUNCH: begin
        state_d = CAPTURE;
        win_d   = WIN_W'(1);
      end
      CAPTURE: begin
        if (win_q == WIN_LAST) begin
          state_d = READOUT;
          win_d   = '0;
        end else begin
          win_d = win_q + 1'b1;
        end
      end
      READOUT: begin
        // First READOUT cycle only arms the handshake, so the consumer always
        // sees o_cap_valid before its done is honoured.
        if (win_q == '0) begin
          win_d = WIN_W'(1);
        end else if (i_rd_done) begin
          state_d = HOLDOFF;
          win_d   = '0;
          hold_d  = '0;
        end
      end
      HOLDOFF: begin
        if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          if (({1'b0, idx_q} + 1'b1) < {1'b0, len_q}) begin
            idx_d   = idx_q + 1'b1;
            state_d = LAUNCH;
          end else begin
            idx_d   = '0;
            state_d = IDLE;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE) begin
      if (i_abort) begin
        state_d   = IDLE;
        win_d     = '0;
        hold_d    = '0;
        idx_d     = '0;
        pending_d = 1'b0;
        drop_inc  = i_trig_manual || auto_tick;
      end else begin
        if (i_trig_manual) begin
          if (pending_q) drop_inc = 1'b1;
          else           pending_d = 1'b1;
        end
        if (auto_tick) drop_inc = 1'b1;
      end
    end

    drop_d = drop_q;
    if (drop_inc && (drop_q != '1)) drop_d = drop_q + 1'b1;
    if (i_clr) begin
      drop_d    = '0;
      pending_d = 1'b0;
    end

    launch_d    = (state_d == LAUNCH);
    cap_en_d    = (state_d == LAUNCH) || (state_d == CAPTURE);
    cap_valid_d = (state_d == READOUT);
    busy_d      = (state_d != IDLE);
  end

  // Scheduler state and output registers.
  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q     <= IDLE;
      win_q       <= '0;
      hold_q      <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      pending_q   <= 1'b0;
      drop_q      <= '0;
      launch_q    <= 1'b0;
      cap_en_q    <= 1'b0;
      cap_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      hold_q      <= hold_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      pending_q   <= pending_d;
      drop_q      <= drop_d;
      launch_q    <= launch_d;
      cap_en_q    <= cap_en_d;
      cap_valid_q <= cap_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign o_launch    = launch_q;
  assign o_cap_en    = cap_en_q;
  assign o_cap_valid = cap_valid_q;
  assign o_busy      = busy_q;
  assign o_burst_idx = idx_q;
  assign o_drop_cnt  = drop_q;

endmodule

// File: tb/tb_dl_capture_sched.sv
// Bench for dl_capture_sched: expected launch cycles/indices go into a
// scoreboard queue when triggers are driven and are popped by a launch monitor.
module tb_dl_capture_sched;

  localparam int DL  = 16;
  localparam int HO  = 64;
  localparam int PW  = 24;
  localparam int BW  = 8;
  localparam int DW  = 8;
  localparam int RUN = DL + 2 + HO;  // launch-to-launch with done held high

  logic          clk;
  logic          i_nrst;
  logic          i_trig_manual;
  logic          i_auto_en;
  logic [PW-1:0] i_auto_period;
  logic [BW-1:0] i_burst_len;
  logic          i_rd_done;
  logic          i_abort;
  logic          i_clr;
  logic          o_launch;
  logic          o_cap_en;
  logic          o_cap_valid;
  logic          o_busy;
  logic [BW-1:0] o_burst_idx;
  logic [DW-1:0] o_drop_cnt;

  dl_capture_sched #(
    .P_DL_LENGTH (DL),
    .P_HOLDOFF   (HO),
    .P_PERIOD_W  (PW),
    .P_BURST_W   (BW),
    .P_DROP_W    (DW)
  ) dut (
    .clk           (clk),
    .i_nrst        (i_nrst),
    .i_trig_manual (i_trig_manual),
    .i_auto_en     (i_auto_en),
    .i_auto_period (i_auto_period),
    .i_burst_len   (i_burst_len),
    .i_rd_done     (i_rd_done),
    .i_abort       (i_abort),
    .i_clr         (i_clr),
    .o_launch      (o_launch),
    .o_cap_en      (o_cap_en),
    .o_cap_valid   (o_cap_valid),
    .o_busy        (o_busy),
    .o_burst_idx   (o_burst_idx),
    .o_drop_cnt    (o_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int idx;
  } launch_t;
  launch_t sb[$];

  typedef struct {
    int len;
    bit tied;
    int rd_off;
    int exp_idle;
    int exp_valid;
  } vec_t;
  vec_t vecs[6];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_launch(input int c, input int idx);
    launch_t e;
    e.cyc = c;
    e.idx = idx;
    sb.push_back(e);
  endtask

  task automatic pulse_clr();
    i_clr = 1'b1;
    step();
    i_clr = 1'b0;
  endtask

  // Launch monitor: every o_launch pulse must match the oldest expectation.
  initial begin
    launch_t e;
    forever begin
      @(posedge clk);
      #2;
      if (o_launch === 1'b1) begin
        check("launch_expected", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("launch_cycle", cyc, e.cyc);
          check("launch_idx", {24'd0, o_burst_idx}, e.idx);
        end
      end
    end
  end

  initial begin
    int t;
    int e;
    int nl;
    int n_launch;
    int n_en;
    int n_val;
    int idle_off;

    // len, tied, rd_off, expected busy-low offset, expected valid cycles
    vecs[0] = '{1, 1'b0, 20, 85, 4};
    vecs[1] = '{3, 1'b1, 0, 247, 6};
    vecs[2] = '{0, 1'b1, 0, 83, 2};
    vecs[3] = '{2, 1'b1, 0, 165, 4};
    vecs[4] = '{1, 1'b0, 40, 105, 24};
    vecs[5] = '{1, 1'b0, 18, 83, 2};

    i_nrst        = 1'b0;
    i_trig_manual = 1'b0;
    i_auto_en     = 1'b0;
    i_auto_period = '0;
    i_burst_len   = BW'(1);
    i_rd_done     = 1'b0;
    i_abort       = 1'b0;
    i_clr         = 1'b0;

    // Reset state
    step(2);
    check("rst_launch", o_launch, 0);
    check("rst_cap_en", o_cap_en, 0);
    check("rst_cap_valid", o_cap_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_idx", o_burst_idx, 0);
    check("rst_drop", o_drop_cnt, 0);
    i_nrst = 1'b1;
    step(3);
    check("post_rst_busy", o_busy, 0);

    // Table-driven single-trigger runs
    for (int v = 0; v < 6; v++) begin
      t             = cyc;
      nl            = (vecs[v].len == 0) ? 1 : vecs[v].len;
      i_burst_len   = BW'(vecs[v].len);
      i_trig_manual = 1'b1;
      i_rd_done     = vecs[v].tied;
      for (int k = 0; k < nl; k++) push_launch(t + 1 + RUN * k, k);
      n_launch = 0;
      n_en     = 0;
      n_val    = 0;
      idle_off = -1;
      for (int off = 1; off <= 260; off++) begin
        step();
        i_trig_manual = 1'b0;
        if (!vecs[v].tied) i_rd_done = (off == vecs[v].rd_off);
        if (o_launch) n_launch++;
        if (o_cap_en) n_en++;
        if (o_cap_valid) n_val++;
        if (idle_off < 0 && !o_busy) idle_off = off;
      end
      i_rd_done = 1'b0;
      check($sformatf("vec%0d_launches", v), n_launch, nl);
      check($sformatf("vec%0d_cap_en_cycles", v), n_en, DL * nl);
      check($sformatf("vec%0d_valid_cycles", v), n_val, vecs[v].exp_valid);
      check($sformatf("vec%0d_idle_offset", v), idle_off, vecs[v].exp_idle);
    end

    // Auto trigger, period 1000 then a change to 50 taking effect at the wrap
    i_rd_done     = 1'b1;
    i_burst_len   = BW'(1);
    i_auto_period = PW'(1000);
    step();
    e = cyc;
    i_auto_en = 1'b1;
    push_launch(e + 1000, 0);
    push_launch(e + 2000, 0);
    push_launch(e + 3000, 0);
    push_launch(e + 3100, 0);
    step(2005);
    i_auto_period = PW'(50);
    step(895);
    check("auto_no_drops", o_drop_cnt, 0);
    step(250);
    i_auto_en = 1'b0;
    check("auto_drops_busy", o_drop_cnt, 2);
    step(100);
    check("auto_idle", o_busy, 0);
    pulse_clr();
    check("auto_clr", o_drop_cnt, 0);
    i_auto_period = '0;

    // Two manual requests during CAPTURE: one pending run, one drop
    t = cyc;
    i_trig_manual = 1'b1;
    push_launch(t + 1, 0);
    push_launch(t + 84, 0);
    step();
    i_trig_manual = 1'b0;
    step(3);
    i_trig_manual = 1'b1;
    step();
    i_trig_manual = 1'b0;
    step(2);
    i_trig_manual = 1'b1;
    step();
    i_trig_manual = 1'b0;
    check("pend_in_capture", o_cap_en, 1);
    check("pend_drop_one", o_drop_cnt, 1);
    step(162);
    check("pend_done_idle", o_busy, 0);
    check("pend_drop_hold", o_drop_cnt, 1);
    pulse_clr();
    check("pend_clr", o_drop_cnt, 0);

    // Abort mid-READOUT with a same-cycle manual trigger
    i_rd_done = 1'b0;
    t = cyc;
    i_trig_manual = 1'b1;
    push_launch(t + 1, 0);
    step();
    i_trig_manual = 1'b0;
    step(19);
    check("abort_pre_valid", o_cap_valid, 1);
    i_abort       = 1'b1;
    i_trig_manual = 1'b1;
    step();
    i_abort       = 1'b0;
    i_trig_manual = 1'b0;
    check("abort_valid", o_cap_valid, 0);
    check("abort_busy", o_busy, 0);
    check("abort_idx", o_burst_idx, 0);
    check("abort_drop", o_drop_cnt, 1);
    step(100);
    pulse_clr();

    // Abort during second run of a burst: index returns to 0
    i_rd_done   = 1'b1;
    i_burst_len = BW'(3);
    t = cyc;
    i_trig_manual = 1'b1;
    push_launch(t + 1, 0);
    push_launch(t + 1 + RUN, 1);
    step();
    i_trig_manual = 1'b0;
    step(86);
    check("burst_abort_pre_idx", o_burst_idx, 1);
    check("burst_abort_pre_en", o_cap_en, 1);
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    check("burst_abort_idx", o_burst_idx, 0);
    check("burst_abort_en", o_cap_en, 0);
    check("burst_abort_busy", o_busy, 0);
    step(100);
    check("burst_abort_drop", o_drop_cnt, 0);

    // Drop counter saturation while held in READOUT
    i_rd_done   = 1'b0;
    i_burst_len = BW'(0);
    t = cyc;
    i_trig_manual = 1'b1;
    push_launch(t + 1, 0);
    step();
    step(301);
    i_trig_manual = 1'b0;
    step();
    check("sat_drop", o_drop_cnt, 255);
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    check("sat_abort_busy", o_busy, 0);
    step(50);
    pulse_clr();
    check("sat_clr", o_drop_cnt, 0);

    // Manual and auto tick in the same IDLE cycle, then async reset mid-CAPTURE
    i_auto_period = PW'(1);
    step();
    i_rd_done   = 1'b1;
    i_burst_len = BW'(1);
    t = cyc;
    i_trig_manual = 1'b1;
    i_auto_en     = 1'b1;
    push_launch(t + 1, 0);
    step();
    i_trig_manual = 1'b0;
    i_auto_en     = 1'b0;
    check("both_drop", o_drop_cnt, 1);
    step(4);
    check("both_capture", o_cap_en, 1);
    #3;
    i_nrst = 1'b0;
    #1;
    check("arst_launch", o_launch, 0);
    check("arst_cap_en", o_cap_en, 0);
    check("arst_valid", o_cap_valid, 0);
    check("arst_busy", o_busy, 0);
    check("arst_idx", o_burst_idx, 0);
    check("arst_drop", o_drop_cnt, 0);
    step(2);
    i_nrst = 1'b1;
    step(100);

    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
